// File: rtl/border_sequencer.sv
// Battle-box border controller: holds the four box edges and animates them toward
// a validated target at STEP pixels per frame tick, with a req/done handshake.
module border_sequencer #(
  parameter int unsigned STEP    = 4,
  parameter int unsigned MIN_GAP = 16,
  parameter int unsigned INIT_X1 = 32,
  parameter int unsigned INIT_X2 = 607,
  parameter int unsigned INIT_Y1 = 240,
  parameter int unsigned INIT_Y2 = 399
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       req_i,
  input  logic       abort_i,
  input  logic [9:0] tgt_x1_i,
  input  logic [9:0] tgt_x2_i,
  input  logic [9:0] tgt_y1_i,
  input  logic [9:0] tgt_y2_i,
  output logic [9:0] border_x1_o,
  output logic [9:0] border_x2_o,
  output logic [9:0] border_y1_o,
  output logic [9:0] border_y2_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [9:0]  STEP_V = 10'(STEP);
  localparam logic [10:0] GAP_V  = 11'(MIN_GAP);
  // Edge index order: 0 = x1, 1 = x2, 2 = y1, 3 = y2.
  localparam logic [3:0][9:0] INIT_V = {10'(INIT_Y2), 10'(INIT_Y1), 10'(INIT_X2), 10'(INIT_X1)};

  state_t           state_q, state_d;
  logic [3:0][9:0]  brd_q, brd_d;
  logic [3:0][9:0]  tgt_q, tgt_d;
  logic             err_q, err_d;

  logic [10:0] dx, dy;
  logic        legal;

  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] res;
    res = tgt;
    if (tgt > cur) begin
      if ((tgt - cur) > STEP_V) res = cur + STEP_V;
    end else begin
      if ((cur - tgt) > STEP_V) res = cur - STEP_V;
    end
    return res;
  endfunction

  // A negative difference sets bit 10, which must reject rather than look huge.
  assign dx    = {1'b0, tgt_x2_i} - {1'b0, tgt_x1_i};
  assign dy    = {1'b0, tgt_y2_i} - {1'b0, tgt_y1_i};
  assign legal = !dx[10] && (dx >= GAP_V) && !dy[10] && (dy >= GAP_V) &&
                 (tgt_x2_i <= 10'd639) && (tgt_y2_i <= 10'd479);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      brd_q   <= INIT_V;
      tgt_q   <= INIT_V;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      brd_q   <= brd_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    brd_d   = brd_q;
    tgt_d   = tgt_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (legal) begin
            tgt_d   = {tgt_y2_i, tgt_y1_i, tgt_x2_i, tgt_x1_i};
            state_d = MOVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MOVE: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (brd_q == tgt_q) begin
          state_d = DONE;
        end else if (tick_i) begin
          for (int i = 0; i < 4; i++) brd_d[i] = step_toward(brd_q[i], tgt_q[i]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign border_x1_o = brd_q[0];
  assign border_x2_o = brd_q[1];
  assign border_y1_o = brd_q[2];
  assign border_y2_o = brd_q[3];
  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q == MOVE) || (state_q == DONE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_border_sequencer.sv
// Bench for border_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against an integer reference model of the box animation.
module tb_border_sequencer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1, tick_i = 1'b0, req_i = 1'b0, abort_i = 1'b0;
  logic [9:0] tgt_x1_i = '0, tgt_x2_i = '0, tgt_y1_i = '0, tgt_y2_i = '0;
  logic [9:0] border_x1_o, border_x2_o, border_y1_o, border_y2_o;
  logic       ready_o, busy_o, done_o, err_o;

  border_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .tick_i(tick_i), .req_i(req_i), .abort_i(abort_i),
    .tgt_x1_i(tgt_x1_i), .tgt_x2_i(tgt_x2_i), .tgt_y1_i(tgt_y1_i), .tgt_y2_i(tgt_y2_i),
    .border_x1_o(border_x1_o), .border_x2_o(border_x2_o),
    .border_y1_o(border_y1_o), .border_y2_o(border_y2_o),
    .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 animating, 2 finished-this-cycle.
  localparam int STEP = 4;
  int init_b[4] = '{32, 607, 240, 399};
  int mb[4] = '{32, 607, 240, 399};
  int mt[4] = '{32, 607, 240, 399};
  int mode  = 0;
  int merr  = 0;
  int w_lo  = 0, w_hi = 0, h_lo = 0, h_hi = 0;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_edge();
    int t[4];
    int d;
    bit same;
    t = '{int'(tgt_x1_i), int'(tgt_x2_i), int'(tgt_y1_i), int'(tgt_y2_i)};
    merr = 0;
    if (reset_i) begin
      mb = init_b; mt = init_b; mode = 0;
      return;
    end
    case (mode)
      0: if (req_i) begin
        if ((t[1] - t[0] >= 16) && (t[3] - t[2] >= 16) && t[1] <= 639 && t[3] <= 479) begin
          w_lo = imin(mb[1] - mb[0], t[1] - t[0]); w_hi = imax(mb[1] - mb[0], t[1] - t[0]);
          h_lo = imin(mb[3] - mb[2], t[3] - t[2]); h_hi = imax(mb[3] - mb[2], t[3] - t[2]);
          mt = t; mode = 1;
        end else merr = 1;
      end
      1: begin
        same = (mb == mt);
        if (abort_i) mode = 0;
        else if (same) mode = 2;
        else if (tick_i)
          for (int i = 0; i < 4; i++) begin
            d = mt[i] - mb[i];
            if (d > STEP) mb[i] += STEP;
            else if (d < -STEP) mb[i] -= STEP;
            else mb[i] = mt[i];
          end
      end
      default: mode = 0;
    endcase
  endtask

  task automatic compare_all();
    int w, h;
    chk("x1", int'(border_x1_o), mb[0]);
    chk("x2", int'(border_x2_o), mb[1]);
    chk("y1", int'(border_y1_o), mb[2]);
    chk("y2", int'(border_y2_o), mb[3]);
    chk("ready", int'(ready_o), int'(mode == 0));
    chk("busy", int'(busy_o), int'(mode != 0));
    chk("done", int'(done_o), int'(mode == 2));
    chk("err", int'(err_o), merr);
    if (mode != 0) begin
      w = int'(border_x2_o) - int'(border_x1_o);
      h = int'(border_y2_o) - int'(border_y1_o);
      chk("width_in_range", int'(w >= w_lo && w <= w_hi), 1);
      chk("height_in_range", int'(h >= h_lo && h <= h_hi), 1);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_tgt(input int x1, input int x2, input int y1, input int y2);
    tgt_x1_i = 10'(x1); tgt_x2_i = 10'(x2); tgt_y1_i = 10'(y1); tgt_y2_i = 10'(y2);
  endtask

  task automatic do_reset();
    reset_i = 1'b1; cyc(); reset_i = 1'b0;
  endtask

  initial begin
    int ticks;
    bit done_seen;
    int done_cnt;

    // Reset and idle
    do_reset();
    repeat (10) cyc();
    chk("rst_x1", int'(border_x1_o), 32);
    chk("rst_x2", int'(border_x2_o), 607);
    chk("rst_y1", int'(border_y1_o), 240);
    chk("rst_y2", int'(border_y2_o), 399);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_busy", int'(busy_o), 0);

    // Long move, one tick every 8 cycles
    set_tgt(240, 400, 240, 399);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    chk("accept_busy", int'(busy_o), 1);
    chk("accept_ready", int'(ready_o), 0);
    ticks = 0; done_seen = 0; done_cnt = 0;
    for (int c = 0; c < 700 && !done_seen; c++) begin
      tick_i = (c % 8 == 0);
      cyc();
      if (tick_i) ticks++;
      if (done_o) begin done_seen = 1; done_cnt++; end
    end
    tick_i = 1'b0;
    chk("move_ticks", ticks, 52);
    chk("move_done_seen", int'(done_seen), 1);
    chk("move_final_x1", int'(border_x1_o), 240);
    chk("move_final_x2", int'(border_x2_o), 400);
    cyc();
    chk("after_done_ready", int'(ready_o), 1);
    chk("after_done_pulse", int'(done_o), 0);

    // Illegal requests
    set_tgt(100, 110, 100, 200);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    chk("narrow_err", int'(err_o), 1);
    chk("narrow_ready", int'(ready_o), 1);
    cyc();
    chk("narrow_err_clear", int'(err_o), 0);
    set_tgt(100, 700, 100, 200);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    chk("wide_err", int'(err_o), 1);
    chk("wide_x1_kept", int'(border_x1_o), 240);
    set_tgt(300, 200, 100, 200);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    chk("reversed_err", int'(err_o), 1);
    cyc();

    // Abort on the 10th tick, with an ignored second request mid-move
    do_reset();
    set_tgt(240, 400, 240, 399);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick_i = 1'b1;
      abort_i = (k == 10);
      if (k == 3) begin req_i = 1'b1; set_tgt(0, 100, 0, 100); end
      cyc();
      req_i = 1'b0;
      if (done_o) done_cnt++;
    end
    tick_i = 1'b0; abort_i = 1'b0;
    chk("abort_x1", int'(border_x1_o), 68);
    chk("abort_x2", int'(border_x2_o), 571);
    chk("abort_ready", int'(ready_o), 1);
    chk("abort_no_done", done_cnt, 0);
    cyc();

    // Reset in the middle of a move
    set_tgt(240, 400, 240, 399);
    req_i = 1'b1; cyc(); req_i = 1'b0;
    tick_i = 1'b1;
    repeat (19) cyc();
    reset_i = 1'b1; cyc(); reset_i = 1'b0; tick_i = 1'b0;
    chk("midrst_x1", int'(border_x1_o), 32);
    chk("midrst_x2", int'(border_x2_o), 607);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);

    // Zero-distance request, held through DONE
    set_tgt(32, 607, 240, 399);
    req_i = 1'b1;
    cyc();
    chk("zero_busy", int'(busy_o), 1);
    cyc();
    chk("zero_done", int'(done_o), 1);
    chk("zero_x1", int'(border_x1_o), 32);
    cyc();
    chk("zero_ready", int'(ready_o), 1);
    cyc();
    chk("zero_reaccept", int'(busy_o), 1);
    req_i = 1'b0;
    repeat (3) cyc();

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      int x1, y1;
      tick_i  = ($urandom_range(0, 3) == 0);
      abort_i = ($urandom_range(0, 99) == 0);
      req_i   = ($urandom_range(0, 9) == 0);
      reset_i = ($urandom_range(0, 999) == 0);
      if (req_i) begin
        if ($urandom_range(0, 7) == 0)
          set_tgt($urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 1023), $urandom_range(0, 1023));
        else begin
          x1 = $urandom_range(0, 600);
          y1 = $urandom_range(0, 440);
          set_tgt(x1, x1 + $urandom_range(16, 639 - x1), y1, y1 + $urandom_range(16, 479 - y1));
        end
      end
      cyc();
    end
    tick_i = 1'b0; abort_i = 1'b0; req_i = 1'b0; reset_i = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
